// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller.
// Holds ALU opcode encodings, flag bit indices, FSM state encoding,
// the instruction field layout and small opcode-class helpers.
package alu_issue_ctrl_pkg;

  localparam int NREGS = 16;
  localparam int WIDTH = 16;
  localparam int AW    = 4;
  localparam int FW    = 5;

  // ALU opcodes; 0000 and 1010 are unassigned and treated as illegal
  localparam logic [3:0] OP_AND   = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_ADDCU = 4'b0100;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_ADDU  = 4'b0110;
  localparam logic [3:0] OP_ADDC  = 4'b0111;
  localparam logic [3:0] OP_CMPU  = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_CMP   = 4'b1011;
  localparam logic [3:0] OP_LSH   = 4'b1100;
  localparam logic [3:0] OP_RSH   = 4'b1101;
  localparam logic [3:0] OP_ALSH  = 4'b1110;
  localparam logic [3:0] OP_ARSH  = 4'b1111;

  // Flag / PSR bit indices
  localparam int FLG_N = 0;
  localparam int FLG_L = 1;
  localparam int FLG_F = 2;
  localparam int FLG_C = 3;
  localparam int FLG_Z = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  // [15:12] opcode, [11:8] rd, [7:4] rs, [3] imm_sel, [2:0] imm3
  typedef struct packed {
    logic [3:0] op;
    logic [3:0] rd;
    logic [3:0] rs;
    logic       imm_sel;
    logic [2:0] imm3;
  } inst_t;

  function automatic logic op_illegal(input logic [3:0] op);
    return (op == 4'b0000) || (op == 4'b1010);
  endfunction

  function automatic logic op_is_cmp(input logic [3:0] op);
    return (op == OP_CMP) || (op == OP_CMPU);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the instruction handshake, ALU drive/return, status and
// debug-read signals of the ALU issue controller.
//   master : instruction source / ALU / debug side
//   slave  : the controller itself
interface alu_issue_ctrl_if;
  import alu_issue_ctrl_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_inst;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_op;
  logic             alu_cin;
  logic [WIDTH-1:0] alu_c;
  logic [FW-1:0]    alu_flags;
  logic [FW-1:0]    psr;
  logic             done;
  logic             err;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output in_valid, in_inst, alu_c, alu_flags, dbg_addr,
    input  in_ready, alu_a, alu_b, alu_op, alu_cin, psr, done, err, dbg_data
  );

  modport slave (
    input  in_valid, in_inst, alu_c, alu_flags, dbg_addr,
    output in_ready, alu_a, alu_b, alu_op, alu_cin, psr, done, err, dbg_data
  );
endinterface

// File: rtl/alu_issue_ctrl_regfile.sv
// regfile_16x16: register file with one write port, two combinational
// operand read ports and one combinational debug read port.
// Ports: clk, rst_n (sync active-low clear of all entries), we/waddr/wdata,
//        raddr_a/rdata_a, raddr_b/rdata_b, dbg_addr/dbg_data.
module regfile_16x16 #(
  parameter int NREGS = 16,
  parameter int WIDTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  logic [WIDTH-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts 16-bit ALU instructions, reads operands from the
// internal register file, drives the external combinational ALU, captures
// its result/flags and retires into the register file and PSR.
// Ports: clk, rst_n (sync active-low), bus (alu_issue_ctrl_if.slave):
//   in_valid/in_ready/in_inst handshake, alu_a/alu_b/alu_op/alu_cin to the
//   ALU, alu_c/alu_flags from it, psr, done/err retire pulses, dbg read.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_ctrl_if.slave    bus
);

  state_t           state_q, state_d;
  inst_t            inst_q;
  logic [WIDTH-1:0] opa_q, opb_q, res_q;
  logic [3:0]       op_q;
  logic [FW-1:0]    flg_q, psr_q;
  logic [WIDTH-1:0] rdata_a, rdata_b;
  logic             accept, wr_en, psr_en;

  assign accept = bus.in_valid && (state_q == ST_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: fixed four-cycle walk once an instruction is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready = (state_q == ST_IDLE);
    bus.done     = (state_q == ST_WB);
    bus.err      = (state_q == ST_WB) && op_illegal(inst_q.op);
    psr_en       = (state_q == ST_WB) && !op_illegal(inst_q.op);
    wr_en        = psr_en && !op_is_cmp(inst_q.op);
  end

  // Datapath registers; operands are held outside EXEC so the ALU inputs
  // never toggle while the controller is idle or writing back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_q <= '0;
      opa_q  <= '0;
      opb_q  <= '0;
      op_q   <= '0;
      res_q  <= '0;
      flg_q  <= '0;
      psr_q  <= '0;
    end else begin
      if (accept) inst_q <= inst_t'(bus.in_inst);
      if (state_q == ST_READ) begin
        opa_q <= rdata_a;
        opb_q <= inst_q.imm_sel ? {13'b0, inst_q.imm3} : rdata_b;
        op_q  <= inst_q.op;
      end
      if (state_q == ST_EXEC) begin
        res_q <= bus.alu_c;
        flg_q <= bus.alu_flags;
      end
      if (psr_en) psr_q <= flg_q;
    end
  end

  assign bus.alu_a   = opa_q;
  assign bus.alu_b   = opb_q;
  assign bus.alu_op  = op_q;
  assign bus.alu_cin = psr_q[FLG_C];
  assign bus.psr     = psr_q;

  regfile_16x16 #(.NREGS(NREGS), .WIDTH(WIDTH), .AW(AW)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wr_en),
    .waddr    (inst_q.rd),
    .wdata    (res_q),
    .raddr_a  (inst_q.rd),
    .rdata_a  (rdata_a),
    .raddr_b  (inst_q.rs),
    .rdata_b  (rdata_b),
    .dbg_addr (bus.dbg_addr),
    .dbg_data (bus.dbg_data)
  );

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU, a register/PSR
// reference model and a queue of expected retirements.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] val;
    logic [4:0]  psr;
    logic        err;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;
  exp_t sb[$];

  logic [15:0] mreg [16];
  logic [4:0]  mpsr;

  // Behavioural ALU
  function automatic void alu_model(input logic [15:0] a, input logic [15:0] b,
                                    input logic [3:0] op, input logic cin,
                                    output logic [15:0] c, output logic [4:0] f);
    logic [16:0] s;
    c = '0;
    f = '0;
    s = '0;
    case (op)
      OP_ADD, OP_ADDU, OP_ADDC, OP_ADDCU: begin
        s = {1'b0, a} + {1'b0, b} + (((op == OP_ADDC) || (op == OP_ADDCU)) ? {16'b0, cin} : 17'd0);
        c = s[15:0];
        f[FLG_C] = s[16];
        f[FLG_F] = (a[15] == b[15]) && (c[15] != a[15]);
      end
      OP_SUB: begin
        c = a - b;
        f[FLG_C] = (a < b);
        f[FLG_F] = (a[15] != b[15]) && (c[15] != a[15]);
      end
      OP_AND: c = a & b;
      OP_OR:  c = a | b;
      OP_XOR: c = a ^ b;
      OP_LSH, OP_ALSH: c = (b >= 16) ? 16'd0 : (a << b[3:0]);
      OP_RSH:  c = (b >= 16) ? 16'd0 : (a >> b[3:0]);
      OP_ARSH: c = (b >= 16) ? 16'd0 : 16'($signed(a) >>> b[3:0]);
      OP_CMP: begin
        f[FLG_N] = ($signed(a) < $signed(b));
        f[FLG_L] = (a < b);
      end
      OP_CMPU: f[FLG_L] = (a < b);
      default: c = '0;
    endcase
    if (op_is_cmp(op)) f[FLG_Z] = (a == b);
    else               f[FLG_Z] = (c == 16'd0);
  endfunction

  logic [15:0] m_c;
  logic [4:0]  m_f;
  always_comb begin
    alu_model(bus.alu_a, bus.alu_b, bus.alu_op, bus.alu_cin, m_c, m_f);
  end
  assign bus.alu_c     = m_c;
  assign bus.alu_flags = m_f;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dbg_check(input string tag, input logic [3:0] addr, input logic [15:0] exp);
    bus.dbg_addr = addr;
    #1;
    check(tag, {16'b0, bus.dbg_data}, {16'b0, exp});
  endtask

  // Issue one instruction, predict its retirement, and check the handshake,
  // latency, operands, err, psr and written register.
  task automatic issue(input string tag, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] rs, input logic imm, input logic [2:0] imm3,
                       input bit chk_cin, input logic exp_cin, input bit hold);
    exp_t e, g;
    logic [15:0] c;
    logic [4:0]  f;
    int lat;
    bit got, acc;
    e.rd  = rd;
    e.a   = mreg[rd];
    e.b   = imm ? {13'b0, imm3} : mreg[rs];
    alu_model(e.a, e.b, op, mpsr[FLG_C], c, f);
    e.err = op_illegal(op);
    e.psr = e.err ? mpsr : f;
    e.val = (e.err || op_is_cmp(op)) ? mreg[rd] : c;
    sb.push_back(e);
    mreg[rd] = e.val;
    mpsr     = e.psr;

    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_inst  = {op, rd, rs, imm, imm3};
    acc = 0;
    for (int w = 0; w < 8 && !acc; w++) begin
      if (bus.in_ready) acc = 1;
      else @(negedge clk);
    end
    check({tag, "_accept"}, {31'b0, acc}, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) bus.in_valid = 1'b0;
    lat = 0;
    got = 0;
    for (int k = 1; k <= 6 && !got; k++) begin
      @(negedge clk);
      if (hold) check({tag, "_busy_ready"}, {31'b0, bus.in_ready}, 32'd0);
      if (k == 2) begin
        check({tag, "_alu_a"}, {16'b0, bus.alu_a}, {16'b0, e.a});
        check({tag, "_alu_b"}, {16'b0, bus.alu_b}, {16'b0, e.b});
        check({tag, "_alu_op"}, {28'b0, bus.alu_op}, {28'b0, op});
        if (chk_cin) check({tag, "_cin"}, {31'b0, bus.alu_cin}, {31'b0, exp_cin});
      end
      if (bus.done) begin
        got = 1;
        lat = k;
        bus.in_valid = 1'b0;
      end
    end
    check({tag, "_latency"}, lat, 32'd3);
    g = sb.pop_front();
    check({tag, "_err"}, {31'b0, bus.err}, {31'b0, g.err});
    @(negedge clk);
    check({tag, "_psr"}, {27'b0, bus.psr}, {27'b0, g.psr});
    dbg_check({tag, "_rd"}, g.rd, g.val);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_inst  = '0;
    bus.dbg_addr = '0;
    for (int i = 0; i < 16; i++) mreg[i] = '0;
    mpsr = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_err", {31'b0, bus.err}, 32'd0);
    check("rst_psr", {27'b0, bus.psr}, 32'd0);
    check("rst_alu_a", {16'b0, bus.alu_a}, 32'd0);
    check("rst_alu_b", {16'b0, bus.alu_b}, 32'd0);
    check("rst_alu_op", {28'b0, bus.alu_op}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) dbg_check("rst_reg", 4'(i), 16'h0000);

    // Immediate path and register add
    issue("addu_r1_imm", OP_ADDU, 4'd1, 4'd0, 1'b1, 3'd3, 0, 1'b0, 0);
    dbg_check("r1_is_3", 4'd1, 16'h0003);
    issue("add_r1_r1", OP_ADD, 4'd1, 4'd1, 1'b0, 3'd0, 0, 1'b0, 0);
    dbg_check("r1_is_6", 4'd1, 16'h0006);
    check("add_psr_z", {31'b0, bus.psr[FLG_Z]}, 32'd0);

    // Carry out, zero result, then carry into ADDCU
    issue("sub_r2", OP_SUB, 4'd2, 4'd0, 1'b1, 3'd1, 0, 1'b0, 0);
    dbg_check("r2_is_ffff", 4'd2, 16'hFFFF);
    issue("addu_r3", OP_ADDU, 4'd3, 4'd0, 1'b1, 3'd1, 0, 1'b0, 0);
    issue("addu_r2_r3", OP_ADDU, 4'd2, 4'd3, 1'b0, 3'd0, 0, 1'b0, 0);
    dbg_check("r2_is_0", 4'd2, 16'h0000);
    check("addu_psr_c", {31'b0, bus.psr[FLG_C]}, 32'd1);
    check("addu_psr_z", {31'b0, bus.psr[FLG_Z]}, 32'd1);
    issue("addcu_r3", OP_ADDCU, 4'd3, 4'd3, 1'b0, 3'd0, 1, 1'b1, 0);
    dbg_check("r3_is_3", 4'd3, 16'h0003);

    // Compare against immediates
    issue("addu_r4", OP_ADDU, 4'd4, 4'd0, 1'b1, 3'd5, 0, 1'b0, 0);
    issue("cmp_r4_7", OP_CMP, 4'd4, 4'd0, 1'b1, 3'd7, 0, 1'b0, 0);
    check("cmp7_psr_nl", {30'b0, bus.psr[1:0]}, 32'd3);
    dbg_check("r4_kept", 4'd4, 16'h0005);
    issue("cmp_r4_2", OP_CMP, 4'd4, 4'd0, 1'b1, 3'd2, 0, 1'b0, 0);
    check("cmp2_psr_nl", {30'b0, bus.psr[1:0]}, 32'd0);

    // Illegal opcodes, with in_valid held through the busy cycles
    issue("ill_1010", 4'b1010, 4'd4, 4'd4, 1'b0, 3'd0, 0, 1'b0, 1);
    dbg_check("ill_r4_kept", 4'd4, 16'h0005);
    issue("ill_0000", 4'b0000, 4'd1, 4'd1, 1'b0, 3'd0, 0, 1'b0, 0);
    dbg_check("ill_r1_kept", 4'd1, 16'h0006);

    // Reset during EXEC aborts the instruction
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_inst  = {OP_ADDU, 4'd5, 4'd0, 1'b1, 3'd1};
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_done", {31'b0, bus.done}, 32'd0);
    check("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("abort_no_done", {31'b0, bus.done}, 32'd0);
    end
    dbg_check("abort_r5", 4'd5, 16'h0000);
    check("abort_psr", {27'b0, bus.psr}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
